// File: rtl/uart_resp_tx.sv
// uart_resp_tx
//   Response framer for the transmit side of the serial control link. On a
//   request it captures one command byte and one payload word. It then hands
//   a fixed-length frame to the UART transmitter one byte at a time:
//     HEADER, cmd, payload bytes (MSB first), XOR checksum (cmd ^ payload).
//   Each byte is offered with a one-cycle o_tx_start pulse. The framer then
//   waits for the transmitter's i_tx_done_tick before moving to the next byte.
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset
//   i_start         one-cycle frame request, honoured only when idle
//   i_cmd           command code, captured with i_start
//   i_payload       payload word (8*PAYLOAD_BYTES), captured with i_start
//   o_busy          frame in progress
//   o_done_tick     one-cycle pulse after the last byte has completed
//   o_tx_start      one-cycle pulse to start the UART on o_tx_data
//   o_tx_data       byte for the UART, held until its done tick
//   i_tx_done_tick  UART byte-complete pulse
module uart_resp_tx #(
    parameter logic [7:0] HEADER        = 8'hA5,
    parameter int         PAYLOAD_BYTES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic [7:0]                 i_cmd,
    input  logic [8*PAYLOAD_BYTES-1:0] i_payload,
    output logic                       o_busy,
    output logic                       o_done_tick,
    output logic                       o_tx_start,
    output logic [7:0]                 o_tx_data,
    input  logic                       i_tx_done_tick
);

    localparam int         PW       = 8 * PAYLOAD_BYTES;
    localparam int         N        = PAYLOAD_BYTES + 3;
    localparam logic [2:0] LAST_IDX = 3'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [PW-1:0]   pay_q, pay_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;

    function automatic logic [7:0] checksum(input logic [7:0] cmd, input logic [PW-1:0] pay);
        logic [7:0] c;
        c = cmd;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            c = c ^ pay[8*i +: 8];
        end
        return c;
    endfunction

    // Byte at a given frame position. Payload byte i (LSB = 0) sits at
    // position N-2-i, so the most significant byte goes out first.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [7:0] cmd,
                                              input logic [PW-1:0] pay);
        logic [7:0] b;
        b = 8'h00;
        if (idx == 3'd0) begin
            b = HEADER;
        end else if (idx == 3'd1) begin
            b = cmd;
        end else if (idx == LAST_IDX) begin
            b = checksum(cmd, pay);
        end else begin
            for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                if (int'(idx) == N - 2 - i) begin
                    b = pay[8*i +: 8];
                end
            end
        end
        return b;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            cmd_q      <= 8'h00;
            pay_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cmd_q      <= cmd_d;
            pay_q      <= pay_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // All outputs are registered. The value that appears during a state is
    // therefore computed on the transition into that state.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cmd_d      = cmd_q;
        pay_d      = pay_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    cmd_d      = i_cmd;
                    pay_d      = i_payload;
                    idx_d      = 3'd0;
                    busy_d     = 1'b1;
                    tx_start_d = 1'b1;
                    // The captured registers are not loaded yet, so the
                    // header is sent directly.
                    tx_data_d  = HEADER;
                    state_d    = SEND;
                end
            end
            SEND: begin
                // A done tick here cannot belong to the byte just started.
                state_d = WAIT;
            end
            WAIT: begin
                if (i_tx_done_tick) begin
                    if (idx_q == LAST_IDX) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        tx_start_d = 1'b1;
                        tx_data_d  = frame_byte(idx_q + 3'd1, cmd_q, pay_q);
                        state_d    = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_busy      = busy_q;
    assign o_done_tick = done_q;
    assign o_tx_start  = tx_start_q;
    assign o_tx_data   = tx_data_q;

endmodule

// File: tb/tb_uart_resp_tx.sv
// tb_uart_resp_tx
//   Bench for uart_resp_tx. Instance A uses the default 2 payload bytes and
//   instance B uses 4 payload bytes. Each instance has a simple UART model
//   that records every started byte and answers with a done tick after a
//   programmable delay. Expected frames come from the frame rules: header,
//   cmd, payload MSB first, then the XOR of cmd and payload.
module tb_uart_resp_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        a_start, a_busy, a_done, a_txs, a_txdone;
    logic [7:0]  a_cmd, a_txd;
    logic [15:0] a_pay;
    logic        a_uart_done = 1'b0;
    logic        a_stray;
    assign a_txdone = a_uart_done | a_stray;

    logic        b_start, b_busy, b_done, b_txs, b_txdone;
    logic [7:0]  b_cmd, b_txd;
    logic [31:0] b_pay;
    logic        b_uart_done = 1'b0;
    assign b_txdone = b_uart_done;

    uart_resp_tx #(.HEADER(8'hA5), .PAYLOAD_BYTES(2)) dut_a (
        .clk(clk), .rst(rst), .i_start(a_start), .i_cmd(a_cmd), .i_payload(a_pay),
        .o_busy(a_busy), .o_done_tick(a_done), .o_tx_start(a_txs), .o_tx_data(a_txd),
        .i_tx_done_tick(a_txdone));

    uart_resp_tx #(.HEADER(8'hA5), .PAYLOAD_BYTES(4)) dut_b (
        .clk(clk), .rst(rst), .i_start(b_start), .i_cmd(b_cmd), .i_payload(b_pay),
        .o_busy(b_busy), .o_done_tick(b_done), .o_tx_start(b_txs), .o_tx_data(b_txd),
        .i_tx_done_tick(b_txdone));

    int n_cmp = 0;
    int n_err = 0;

    // UART models: record bytes, flag protocol violations, return done ticks.
    int   a_dly = 20, a_cnt = 0, a_nstart = 0, a_ndone = 0, a_proto = 0;
    bit   a_await = 0, a_prev = 0;
    logic [7:0] a_rec[$];
    always @(negedge clk) begin
        a_uart_done = 1'b0;
        if (a_cnt > 0) begin
            a_cnt = a_cnt - 1;
            if (a_cnt == 0) begin a_uart_done = 1'b1; a_await = 0; end
        end
        if (a_done === 1'b1) a_ndone = a_ndone + 1;
        if (a_txs === 1'b1) begin
            if (a_await || a_prev) a_proto = a_proto + 1;
            a_rec.push_back(a_txd);
            a_nstart = a_nstart + 1;
            a_await  = 1;
            a_cnt    = a_dly;
        end
        a_prev = (a_txs === 1'b1);
    end

    int   b_cnt = 0, b_proto = 0;
    bit   b_await = 0, b_prev = 0;
    logic [7:0] b_rec[$];
    always @(negedge clk) begin
        b_uart_done = 1'b0;
        if (b_cnt > 0) begin
            b_cnt = b_cnt - 1;
            if (b_cnt == 0) begin b_uart_done = 1'b1; b_await = 0; end
        end
        if (b_txs === 1'b1) begin
            if (b_await || b_prev) b_proto = b_proto + 1;
            b_rec.push_back(b_txd);
            b_await = 1;
            b_cnt   = 3;
        end
        b_prev = (b_txs === 1'b1);
    end

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference frame built straight from the byte-order and checksum rules.
    task automatic model(input logic [7:0] cmd, input logic [31:0] pay, input int pb);
        logic [7:0] cs, b;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(cmd);
        cs = cmd;
        for (int i = pb - 1; i >= 0; i--) begin
            b = pay[8*i +: 8];
            exp_q.push_back(b);
            cs = cs ^ b;
        end
        exp_q.push_back(cs);
    endtask

    task automatic collect(input bit sel, input int base);
        got_q.delete();
        if (!sel) for (int i = base; i < a_rec.size(); i++) got_q.push_back(a_rec[i]);
        else      for (int i = base; i < b_rec.size(); i++) got_q.push_back(b_rec[i]);
    endtask

    task automatic cmp_frame(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    function automatic int rec_size(input bit sel);
        return sel ? b_rec.size() : a_rec.size();
    endfunction

    // Called at a falling edge. Leaves the caller at the falling edge of cycle 1.
    task automatic start_frame(input bit sel, input logic [7:0] c, input logic [31:0] p,
                               input string tag);
        if (!sel) begin a_start = 1'b1; a_cmd = c; a_pay = p[15:0]; end
        else      begin b_start = 1'b1; b_cmd = c; b_pay = p; end
        @(negedge clk);
        a_start = 1'b0; b_start = 1'b0;
        a_cmd = 8'($urandom); a_pay = 16'($urandom);
        b_cmd = 8'($urandom); b_pay = $urandom;
        check({tag, "_busy_c1"},  sel ? b_busy : a_busy, 1);
        check({tag, "_start_c1"}, sel ? b_txs : a_txs, 1);
        check({tag, "_hdr_c1"},   sel ? b_txd : a_txd, 8'hA5);
    endtask

    task automatic wait_done(input bit sel, input string tag);
        int n;
        n = 0;
        while ((sel ? b_done : a_done) !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, sel ? b_done : a_done, 1);
        check({tag, "_busy_at_done"}, sel ? b_busy : a_busy, 0);
    endtask

    task automatic run_frame(input bit sel, input logic [7:0] c, input logic [31:0] p,
                             input string tag);
        int base;
        base = rec_size(sel);
        start_frame(sel, c, p, tag);
        wait_done(sel, tag);
        model(c, p, sel ? 4 : 2);
        collect(sel, base);
        cmp_frame(tag);
    endtask

    initial begin
        int base, nst, nd, n;
        logic [7:0]  c;
        logic [31:0] p;
        rst = 1'b1;
        a_start = 1'b0; a_cmd = 8'h00; a_pay = 16'h0000; a_stray = 1'b0;
        b_start = 1'b0; b_cmd = 8'h00; b_pay = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_done", a_done, 0);
        check("rst_a_txs",  a_txs, 0);
        check("rst_a_txd",  a_txd, 0);
        check("rst_b_txd",  b_txd, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame, with an ignored request in the middle of it.
        base = a_rec.size(); nst = a_nstart; nd = a_ndone;
        start_frame(0, 8'h10, 32'h1234, "basic");
        repeat (30) @(negedge clk);
        a_start = 1'b1; a_cmd = 8'h55; a_pay = 16'hBEEF;
        @(negedge clk);
        a_start = 1'b0;
        wait_done(0, "basic");
        model(8'h10, 32'h1234, 2);
        collect(0, base);
        cmp_frame("basic");
        check("basic_nstart", a_nstart - nst, 5);
        repeat (60) @(negedge clk);
        check("ignored_no_frame", a_nstart - nst, 5);
        check("ignored_idle_busy", a_busy, 0);
        check("basic_ndone", a_ndone - nd, 1);

        // Back-to-back: a new request in the same cycle as o_done_tick.
        a_dly = 5;
        c = 8'($urandom); p = $urandom;
        run_frame(0, c, p, "b2b_first");
        base = a_rec.size();
        start_frame(0, 8'h01, 32'h0000, "b2b_second");
        wait_done(0, "b2b_second");
        model(8'h01, 32'h0000, 2);
        collect(0, base);
        cmp_frame("b2b_second");

        // Stray done ticks: in IDLE, then during the SEND cycle.
        @(negedge clk);
        nst = a_nstart;
        a_stray = 1'b1;
        @(negedge clk);
        a_stray = 1'b0;
        repeat (5) @(negedge clk);
        check("stray_idle_busy", a_busy, 0);
        check("stray_idle_nstart", a_nstart - nst, 0);
        base = a_rec.size();
        c = 8'($urandom); p = $urandom;
        start_frame(0, c, p, "stray_send");
        a_stray = 1'b1;
        @(negedge clk);
        a_stray = 1'b0;
        check("stray_send_c2_txs", a_txs, 0);
        check("stray_send_c2_busy", a_busy, 1);
        wait_done(0, "stray_send");
        model(c, p, 2);
        collect(0, base);
        cmp_frame("stray_send");

        // Reset while payload MSB byte (index 2) is in flight.
        a_dly = 20;
        @(negedge clk);
        base = a_rec.size(); nst = a_nstart;
        start_frame(0, 8'h3C, 32'h8177, "rstmid");
        n = 0;
        while (a_rec.size() - base < 3 && n < 500) begin @(negedge clk); n++; end
        check("rstmid_reached_idx2", a_rec.size() - base, 3);
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rstmid_async_busy", a_busy, 0);
        check("rstmid_async_done", a_done, 0);
        check("rstmid_async_txs",  a_txs, 0);
        check("rstmid_async_txd",  a_txd, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("rstmid_late_tick_busy", a_busy, 0);
        check("rstmid_late_tick_nstart", a_nstart - nst, 3);
        c = 8'($urandom); p = $urandom;
        run_frame(0, c, p, "after_rst");

        // Randomised frames with random UART byte times.
        for (int k = 0; k < 6; k++) begin
            a_dly = int'($urandom_range(1, 12));
            c = 8'($urandom); p = $urandom;
            @(negedge clk);
            run_frame(0, c, p, $sformatf("rand%0d", k));
        end

        // Four payload bytes.
        run_frame(1, 8'hFF, 32'hDEADBEEF, "pb4_fixed");
        for (int k = 0; k < 3; k++) begin
            c = 8'($urandom); p = $urandom;
            @(negedge clk);
            run_frame(1, c, p, $sformatf("pb4_rand%0d", k));
        end

        check("a_protocol_violations", a_proto, 0);
        check("b_protocol_violations", b_proto, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
